// File: rtl/plab4_net_router_output_sched_tdm_pkg.sv
// Shared definitions for the TDM output scheduler: epoch FSM encoding and
// domain tag width.
package plab4_net_router_output_sched_tdm_pkg;

  // Epoch FSM: ACTIVE epochs carry traffic for cur_domain, DEAD cycles are
  // idle turnaround between epochs.
  typedef enum logic {
    ST_ACTIVE = 1'b0,
    ST_DEAD   = 1'b1
  } sched_state_e;

  // Width of a security domain tag (two domains, 0 and 1).
  localparam int c_domain_w = 1;

endpackage

// File: rtl/plab4_net_router_sched_rr_pick.sv
// Combinational rotating picker: returns the first set bit of the eligible
// mask at or after the start pointer, wrapping around, as one-hot plus index.
module plab4_net_router_sched_rr_pick #(
  parameter int p_num_in = 3
) (
  input  logic [p_num_in-1:0] elig,
  input  logic [1:0]          ptr,
  output logic [p_num_in-1:0] grant,
  output logic [1:0]          idx
);

  int   j;
  logic found;

  // Scan offsets 0..p_num_in-1 from ptr; the first eligible input wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < p_num_in; k++) begin
      j = (int'(ptr) + k) % p_num_in;
      if (!found && elig[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = j[1:0];
      end
    end
  end

endmodule

// File: rtl/plab4_net_router_output_sched_tdm.sv
// Domain-aware time-multiplexed scheduler for one router output port.
// Fixed-length epochs alternate between domain 0 and domain 1 with dead
// cycles in between; each domain keeps its own round-robin pointer and
// packet lock, so a packet interrupted by an epoch end resumes in the next
// epoch of its own domain.
//
// Handshake: a flit moves on a cycle where grants[i] is set. out_rdy is
// folded into the grant, so grants/out_val are only asserted when the
// downstream can accept; reqs[i] must stay high until its flit is granted.
module plab4_net_router_output_sched_tdm
  import plab4_net_router_output_sched_tdm_pkg::*;
#(
  parameter int p_num_in      = 3,
  parameter int p_epoch_len   = 8,
  parameter int p_dead_cycles = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [p_num_in-1:0] reqs,
  input  logic [p_num_in-1:0] reqs_domain,
  input  logic [p_num_in-1:0] reqs_tail,
  input  logic                out_rdy,
  output logic [p_num_in-1:0] grants,
  output logic                out_val,
  output logic                out_domain,
  output logic [1:0]          xbar_sel,
  output logic                dbg_state
);

  localparam int c_cnt_max = (p_epoch_len > p_dead_cycles) ? p_epoch_len : p_dead_cycles;
  localparam int c_cnt_w   = $clog2(c_cnt_max + 1);
  localparam logic [c_cnt_w-1:0] c_epoch_load = c_cnt_w'(p_epoch_len - 1);
  localparam logic [c_cnt_w-1:0] c_dead_load  = c_cnt_w'(p_dead_cycles - 1);
  localparam logic [1:0]         c_last_idx   = 2'(p_num_in - 1);

  sched_state_e            state_q, state_d;
  logic [c_cnt_w-1:0]      cnt_q, cnt_d;
  logic [c_domain_w-1:0]   cur_domain_q, cur_domain_d;
  logic [1:0]              rr_ptr_q [2];
  logic [1:0]              rr_ptr_d [2];
  logic [1:0]              lock_q, lock_d;
  logic [1:0]              lock_idx_q [2];
  logic [1:0]              lock_idx_d [2];
  logic [1:0]              xbar_sel_q, xbar_sel_d;

  logic [c_domain_w-1:0]   oth_domain;
  logic [p_num_in-1:0]     elig_raw;
  logic [p_num_in-1:0]     elig;
  logic [1:0]              pick_ptr;
  logic [p_num_in-1:0]     pick_grant;
  logic [1:0]              pick_idx;

  assign oth_domain = ~cur_domain_q;

  // Epoch timer: free-running, independent of traffic and out_rdy.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cur_domain_d = cur_domain_q;
    if (cnt_q == '0) begin
      if (state_q == ST_ACTIVE) begin
        state_d      = ST_DEAD;
        cur_domain_d = ~cur_domain_q;
        cnt_d        = c_dead_load;
      end else begin
        state_d = ST_ACTIVE;
        cnt_d   = c_epoch_load;
      end
    end else begin
      cnt_d = cnt_q - c_cnt_w'(1);
    end
  end

  // Eligibility mask and picker start point. An input that is mid-packet
  // under the other domain's lock is excluded so its packet is never split
  // across domains; a lock in the current domain restricts the pick to the
  // locked input.
  always_comb begin
    elig_raw = '0;
    for (int i = 0; i < p_num_in; i++) begin
      elig_raw[i] = (state_q == ST_ACTIVE) && out_rdy && reqs[i]
                    && (reqs_domain[i] == cur_domain_q)
                    && !(lock_q[oth_domain] && (lock_idx_q[oth_domain] == 2'(i)));
    end
    if (lock_q[cur_domain_q]) begin
      elig     = elig_raw & ({{(p_num_in-1){1'b0}}, 1'b1} << lock_idx_q[cur_domain_q]);
      pick_ptr = lock_idx_q[cur_domain_q];
    end else begin
      elig     = elig_raw;
      pick_ptr = rr_ptr_q[cur_domain_q];
    end
  end

  plab4_net_router_sched_rr_pick #(
    .p_num_in (p_num_in)
  ) u_rr_pick (
    .elig  (elig),
    .ptr   (pick_ptr),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

  assign grants     = pick_grant;
  assign out_val    = |pick_grant;
  assign out_domain = cur_domain_q;
  assign dbg_state  = (state_q == ST_DEAD);
  assign xbar_sel   = xbar_sel_d;

  // Per-domain pointer/lock update on a transfer; only the current domain's
  // entry is touched. xbar_sel follows the grant and holds when idle.
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    xbar_sel_d = xbar_sel_q;
    if (out_val) begin
      xbar_sel_d = pick_idx;
      if (reqs_tail[pick_idx]) begin
        lock_d[cur_domain_q]   = 1'b0;
        rr_ptr_d[cur_domain_q] = (pick_idx == c_last_idx) ? 2'd0 : pick_idx + 2'd1;
      end else begin
        lock_d[cur_domain_q]     = 1'b1;
        lock_idx_d[cur_domain_q] = pick_idx;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_ACTIVE;
      cnt_q         <= c_epoch_load;
      cur_domain_q  <= '0;
      rr_ptr_q[0]   <= 2'd0;
      rr_ptr_q[1]   <= 2'd0;
      lock_q        <= 2'b00;
      lock_idx_q[0] <= 2'd0;
      lock_idx_q[1] <= 2'd0;
      xbar_sel_q    <= 2'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cur_domain_q <= cur_domain_d;
      rr_ptr_q     <= rr_ptr_d;
      lock_q       <= lock_d;
      lock_idx_q   <= lock_idx_d;
      xbar_sel_q   <= xbar_sel_d;
    end
  end

endmodule

// File: tb/tb_plab4_net_router_output_sched_tdm.sv
// Directed bench for the TDM output scheduler. Cycle c is counted from the
// first cycle after reset is released; inputs are driven 1 time unit after
// the rising edge and outputs are sampled at the falling edge.
module tb_plab4_net_router_output_sched_tdm;

  logic       clk;
  logic       reset;
  logic [2:0] reqs;
  logic [2:0] reqs_domain;
  logic [2:0] reqs_tail;
  logic       out_rdy;
  logic [2:0] grants;
  logic       out_val;
  logic       out_domain;
  logic [1:0] xbar_sel;
  logic       dbg_state;

  int checks;
  int failures;

  plab4_net_router_output_sched_tdm #(
    .p_num_in      (3),
    .p_epoch_len   (8),
    .p_dead_cycles (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .reqs        (reqs),
    .reqs_domain (reqs_domain),
    .reqs_tail   (reqs_tail),
    .out_rdy     (out_rdy),
    .grants      (grants),
    .out_val     (out_val),
    .out_domain  (out_domain),
    .xbar_sel    (xbar_sel),
    .dbg_state   (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic reset_dut;
    reset       = 1'b1;
    reqs        = '0;
    reqs_domain = '0;
    reqs_tail   = '0;
    out_rdy     = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset_dut();
    #4;
    checks++;
    if (grants !== 3'b000 || out_val !== 1'b0) begin
      failures++;
      $display("FAIL reset_grants got=%b/%b exp=000/0", grants, out_val);
    end
    checks++;
    if (xbar_sel !== 2'd0 || out_domain !== 1'b0 || dbg_state !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got xbar=%0d dom=%b dead=%b exp 0/0/0", xbar_sel, out_domain, dbg_state);
    end
  endtask

  // All three inputs, domain 0, single-flit packets.
  task automatic test_rr_epoch;
    logic [2:0] eg;
    logic [1:0] ex;
    logic       ed;
    logic       es;
    reset_dut();
    for (int c = 0; c <= 20; c++) begin
      reqs = 3'b111; reqs_domain = 3'b000; reqs_tail = 3'b111; out_rdy = 1'b1;
      if (c < 8) begin
        eg = 3'b001 << (c % 3); ex = 2'(c % 3);
      end else if (c < 20) begin
        eg = 3'b000; ex = 2'd1;
      end else begin
        eg = 3'b100; ex = 2'd2;
      end
      ed = (c >= 8 && c <= 17);
      es = (c == 8 || c == 9 || c == 18 || c == 19);
      #4;
      checks++;
      if (grants !== eg || out_val !== (|eg)) begin
        failures++;
        $display("FAIL rr_grants c=%0d got=%b/%b exp=%b", c, grants, out_val, eg);
      end
      checks++;
      if (xbar_sel !== ex || out_domain !== ed || dbg_state !== es) begin
        failures++;
        $display("FAIL rr_state c=%0d got xbar=%0d dom=%b dead=%b exp %0d/%b/%b",
                 c, xbar_sel, out_domain, dbg_state, ex, ed, es);
      end
      next_cycle();
    end
  endtask

  // in1 3-flit packet starting at cycle 6, suspended across the domain-1 epoch.
  task automatic test_lock_suspend;
    logic [2:0] eg;
    logic [1:0] ex;
    reset_dut();
    for (int c = 0; c <= 21; c++) begin
      reqs        = {1'b0, (c >= 6 && c <= 20), 1'b1};
      reqs_domain = 3'b000;
      reqs_tail   = {1'b0, (c == 20), 1'b1};
      out_rdy     = 1'b1;
      if (c < 6)                 begin eg = 3'b001; ex = 2'd0; end
      else if (c < 8)            begin eg = 3'b010; ex = 2'd1; end
      else if (c < 20)           begin eg = 3'b000; ex = 2'd1; end
      else if (c == 20)          begin eg = 3'b010; ex = 2'd1; end
      else                       begin eg = 3'b001; ex = 2'd0; end
      #4;
      checks++;
      if (grants !== eg || xbar_sel !== ex) begin
        failures++;
        $display("FAIL lock_suspend c=%0d got=%b sel=%0d exp=%b sel=%0d", c, grants, xbar_sel, eg, ex);
      end
      next_cycle();
    end
  endtask

  // Same domain-0 stimulus with and without domain-1 traffic on in2.
  task automatic test_domain_isolation(input logic with_d1);
    logic [2:0] eg;
    logic [1:0] ex;
    logic       ed;
    reset_dut();
    ex = 2'd0;
    for (int c = 0; c <= 27; c++) begin
      reqs        = {with_d1, 2'b11};
      reqs_domain = 3'b100;
      reqs_tail   = 3'b111;
      out_rdy     = 1'b1;
      if (c < 8)                  eg = (c % 2 == 0) ? 3'b001 : 3'b010;
      else if (c >= 10 && c < 18) eg = with_d1 ? 3'b100 : 3'b000;
      else if (c >= 20)           eg = ((c - 20) % 2 == 0) ? 3'b001 : 3'b010;
      else                        eg = 3'b000;
      if (eg == 3'b001) ex = 2'd0;
      if (eg == 3'b010) ex = 2'd1;
      if (eg == 3'b100) ex = 2'd2;
      ed = (c >= 8 && c <= 17);
      #4;
      checks++;
      if (grants !== eg || xbar_sel !== ex || out_domain !== ed) begin
        failures++;
        $display("FAIL isolation d1=%b c=%0d got=%b sel=%0d dom=%b exp=%b sel=%0d dom=%b",
                 with_d1, c, grants, xbar_sel, out_domain, eg, ex, ed);
      end
      next_cycle();
    end
  endtask

  // out_rdy low in cycles 2-4: no grant, no pointer advance, timer unaffected.
  task automatic test_backpressure;
    logic [2:0] eg_tab [10];
    logic [1:0] ex_tab [10];
    eg_tab = '{3'b001, 3'b010, 3'b000, 3'b000, 3'b000, 3'b001, 3'b010, 3'b001, 3'b000, 3'b000};
    ex_tab = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0};
    reset_dut();
    for (int c = 0; c <= 9; c++) begin
      reqs = 3'b011; reqs_domain = 3'b000; reqs_tail = 3'b111;
      out_rdy = !(c >= 2 && c <= 4);
      #4;
      checks++;
      if (grants !== eg_tab[c] || xbar_sel !== ex_tab[c]) begin
        failures++;
        $display("FAIL backpressure c=%0d got=%b sel=%0d exp=%b sel=%0d", c, grants, xbar_sel, eg_tab[c], ex_tab[c]);
      end
      checks++;
      if (dbg_state !== (c >= 8) || out_domain !== (c >= 8)) begin
        failures++;
        $display("FAIL backpressure_timer c=%0d got dead=%b dom=%b exp %b", c, dbg_state, out_domain, (c >= 8));
      end
      next_cycle();
    end
  endtask

  // Reset while in2 holds a domain-0 lock.
  task automatic test_reset_mid_packet;
    reset_dut();
    reqs = 3'b100; reqs_domain = 3'b000; reqs_tail = 3'b000;
    for (int c = 0; c < 2; c++) begin
      #4;
      checks++;
      if (grants !== 3'b100) begin
        failures++;
        $display("FAIL rst_mid_pre c=%0d got=%b exp=100", c, grants);
      end
      next_cycle();
    end
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    reqs = 3'b101; reqs_tail = 3'b001;
    #4;
    checks++;
    if (grants !== 3'b001 || dbg_state !== 1'b0 || out_domain !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_first got=%b dead=%b dom=%b exp=001/0/0", grants, dbg_state, out_domain);
    end
    next_cycle();
    reqs = 3'b001;
    for (int c = 1; c <= 8; c++) begin
      #4;
      checks++;
      if (grants !== ((c < 8) ? 3'b001 : 3'b000) || dbg_state !== (c == 8)) begin
        failures++;
        $display("FAIL rst_mid_epoch c=%0d got=%b dead=%b exp=%b dead=%b",
                 c, grants, dbg_state, (c < 8) ? 3'b001 : 3'b000, (c == 8));
      end
      next_cycle();
    end
  endtask

  // Locked in2 flips its domain tag mid-packet, then returns to domain 0.
  task automatic test_lock_domain_switch;
    logic [2:0] eg;
    logic [1:0] ex;
    reset_dut();
    for (int c = 0; c <= 21; c++) begin
      out_rdy = 1'b1;
      if (c == 0) begin
        reqs = 3'b100; reqs_domain = 3'b000; reqs_tail = 3'b000;
        eg = 3'b100; ex = 2'd2;
      end else if (c < 20) begin
        reqs = 3'b101; reqs_domain = 3'b100; reqs_tail = 3'b001;
        eg = 3'b000; ex = 2'd2;
      end else if (c == 20) begin
        reqs = 3'b101; reqs_domain = 3'b000; reqs_tail = 3'b101;
        eg = 3'b100; ex = 2'd2;
      end else begin
        reqs = 3'b001; reqs_domain = 3'b000; reqs_tail = 3'b001;
        eg = 3'b001; ex = 2'd0;
      end
      #4;
      checks++;
      if (grants !== eg || xbar_sel !== ex) begin
        failures++;
        $display("FAIL lock_domain_switch c=%0d got=%b sel=%0d exp=%b sel=%0d", c, grants, xbar_sel, eg, ex);
      end
      next_cycle();
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_rr_epoch();
    test_lock_suspend();
    test_domain_isolation(1'b0);
    test_domain_isolation(1'b1);
    test_backpressure();
    test_reset_mid_packet();
    test_lock_domain_switch();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
